// File: rtl/rom_loader_if.sv
// rom_loader_if: word stream from a producer into rom_loader.
//
// Handshake: the producer drives in_valid/in_data. The loader drives
// in_ready. A word moves on a rising clk edge where in_valid and in_ready
// are both 1. in_ready never depends on in_valid. The producer holds
// in_data stable while in_valid is 1 and in_ready is 0.
//
// Signals:
//   in_valid  producer -> loader  in_data holds a valid word
//   in_data   producer -> loader  word to write (WIDTH bits)
//   in_ready  loader -> producer  loader accepts a word this cycle
interface rom_loader_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/rom_loader.sv
// rom_loader: fills a synchronous-read memory from a word stream at run time.
// Words arrive on the stream interface and are written to addresses
// 0..DEPTH-1 in order. The loader keeps a running modulo-2^WIDTH checksum
// and flags completion. The read port has the same 1-cycle latency as the
// ROM it replaces.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      begin a load at address 0 (honoured in IDLE and DONE)
//   abort      cancel the load in progress (honoured in LOAD)
//   stream     in_valid / in_data / in_ready word stream (slave side)
//   busy       load in progress
//   done       all DEPTH words written since the last start
//   wr_count   words written in the current or most recent load
//   checksum   sum of accepted words, modulo 2^WIDTH
//   addr_rd    read address
//   data_out   registered read data, 1-cycle latency
//   state_dbg  current FSM state (0 IDLE, 1 LOAD, 2 DONE)
module rom_loader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int DEPTH_LOG = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    rom_loader_if.slave          stream,
    output logic                 busy,
    output logic                 done,
    output logic [DEPTH_LOG:0]   wr_count,
    output logic [WIDTH-1:0]     checksum,
    input  logic [DEPTH_LOG-1:0] addr_rd,
    output logic [WIDTH-1:0]     data_out,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEPTH_LOG-1:0] ptr;
    logic                 accept;
    logic                 last;
    logic                 restart;

    // abort wins over a same-cycle transfer, so it masks the write here.
    assign accept  = (state == ST_LOAD) && stream.in_valid && !abort;
    assign last    = (ptr == DEPTH_LOG'(DEPTH - 1));
    assign restart = start && (state != ST_LOAD);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (stream.in_valid && last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: if (start) state_nxt = ST_LOAD;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        stream.in_ready = (state == ST_LOAD);
        busy            = (state == ST_LOAD);
        state_dbg       = state;
    end

    // Pointer, counters and read register. The pointer wraps to 0 after
    // the last word because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr      <= '0;
            wr_count <= '0;
            checksum <= '0;
            done     <= 1'b0;
            data_out <= '0;
        end else begin
            data_out <= mem[addr_rd];
            if (restart) begin
                ptr      <= '0;
                wr_count <= '0;
                checksum <= '0;
                done     <= 1'b0;
            end else if (accept) begin
                ptr      <= ptr + 1'b1;
                wr_count <= wr_count + 1'b1;
                checksum <= checksum + stream.in_data;
                if (last) done <= 1'b1;
            end
        end
    end

    // The array has no reset. Words written before a reset survive it.
    // A read of the address being written returns the old word because
    // data_out samples mem before this write lands.
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            mem[ptr] <= stream.in_data;
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: self-checking bench for rom_loader (WIDTH=8, DEPTH=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rom_loader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [3:0] addr_rd;
    logic       busy;
    logic       done;
    logic [4:0] wr_count;
    logic [7:0] checksum;
    logic [7:0] data_out;
    logic [1:0] state_dbg;

    rom_loader_if #(.WIDTH(8)) sif ();

    rom_loader #(.WIDTH(8), .DEPTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .stream    (sif),
        .busy      (busy),
        .done      (done),
        .wr_count  (wr_count),
        .checksum  (checksum),
        .addr_rd   (addr_rd),
        .data_out  (data_out),
        .state_dbg (state_dbg)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // reference model (0 IDLE, 1 LOAD, 2 DONE)
    int         m_state;
    logic [3:0] m_ptr;
    logic [4:0] m_count;
    logic [7:0] m_csum;
    logic       m_done;
    logic [7:0] m_mem [16];

    // scoreboard for read data
    logic [7:0] exp_q [$];
    logic [7:0] exp_v;

    // one clock cycle of stimulus; the model predicts the effect of the edge
    task automatic step(input logic s, input logic a, input logic v, input logic [7:0] d);
        start = s;
        abort = a;
        sif.in_valid = v;
        sif.in_data = d;
        case (m_state)
            0, 2: begin
                if (s) begin
                    m_state = 1;
                    m_ptr = 0;
                    m_count = 0;
                    m_csum = 0;
                    m_done = 0;
                end
            end
            default: begin
                if (a) begin
                    m_state = 0;
                end else if (v) begin
                    m_mem[m_ptr] = d;
                    m_csum = m_csum + d;
                    m_count = m_count + 1;
                    if (m_ptr == 4'd15) begin
                        m_state = 2;
                        m_done = 1;
                    end
                    m_ptr = m_ptr + 1;
                end
            end
        endcase
        @(negedge clk);
        start = 0;
        abort = 0;
        sif.in_valid = 0;
    endtask

    // one cycle with rst_n low; the memory model is untouched
    task automatic reset_cycle(input logic v, input logic [7:0] d);
        rst_n = 0;
        sif.in_valid = v;
        sif.in_data = d;
        m_state = 0;
        m_ptr = 0;
        m_count = 0;
        m_csum = 0;
        m_done = 0;
        @(negedge clk);
        rst_n = 1;
        sif.in_valid = 0;
    endtask

    task automatic test_reset();
        reset_cycle(0, 8'h00);
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
        chk_cnt++; if (wr_count !== 5'd0) $display("FAIL reset_wr_count: got %0d expected 0", wr_count); else pass_cnt++;
        chk_cnt++; if (checksum !== 8'h00) $display("FAIL reset_checksum: got %h expected 00", checksum); else pass_cnt++;
        chk_cnt++; if (data_out !== 8'h00) $display("FAIL reset_data_out: got %h expected 00", data_out); else pass_cnt++;
        chk_cnt++; if (sif.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", sif.in_ready); else pass_cnt++;
        chk_cnt++; if (state_dbg !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state_dbg); else pass_cnt++;
    endtask

    task automatic test_full_load();
        int rdy;
        step(1, 0, 0, 8'h00);
        chk_cnt++; if (busy !== 1'b1) $display("FAIL full_busy_start: got %b expected 1", busy); else pass_cnt++;
        rdy = 0;
        // two extra cycles after the 16th word: in_ready must already be low
        for (int i = 0; i < 18; i++) begin
            if (sif.in_ready === 1'b1) rdy++;
            step(0, 0, 1, (i < 16) ? 8'(i) : 8'h99);
        end
        chk_cnt++; if (rdy !== 16) $display("FAIL full_ready_cycles: got %0d expected 16", rdy); else pass_cnt++;
        chk_cnt++; if (done !== 1'b1) $display("FAIL full_done: got %b expected 1", done); else pass_cnt++;
        chk_cnt++; if (wr_count !== 5'd16) $display("FAIL full_wr_count: got %0d expected 16", wr_count); else pass_cnt++;
        chk_cnt++; if (checksum !== 8'h78) $display("FAIL full_checksum: got %h expected 78", checksum); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL full_busy_end: got %b expected 0", busy); else pass_cnt++;
        chk_cnt++; if (state_dbg !== 2'd2) $display("FAIL full_state: got %0d expected 2", state_dbg); else pass_cnt++;
        // pipelined reads: each address is compared one cycle after it is applied
        for (int a = 0; a <= 16; a++) begin
            if (a > 0) begin
                exp_v = exp_q.pop_front();
                chk_cnt++; if (data_out !== exp_v) $display("FAIL full_read[%0d]: got %h expected %h", a - 1, data_out, exp_v); else pass_cnt++;
            end
            if (a < 16) begin
                addr_rd = 4'(a);
                exp_q.push_back(8'(a));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        step(1, 0, 0, 8'h00);   // start from DONE
        chk_cnt++; if (done !== 1'b0) $display("FAIL stall_done_drop: got %b expected 0", done); else pass_cnt++;
        chk_cnt++; if (wr_count !== 5'd0) $display("FAIL stall_wr_count_clear: got %0d expected 0", wr_count); else pass_cnt++;
        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0) begin
                step(0, 0, 1, 8'(i / 2));
            end else begin
                step(0, 0, 0, 8'hEE);
                chk_cnt++; if (wr_count !== m_count) $display("FAIL stall_count[%0d]: got %0d expected %0d", i, wr_count, m_count); else pass_cnt++;
                chk_cnt++; if (checksum !== m_csum) $display("FAIL stall_csum[%0d]: got %h expected %h", i, checksum, m_csum); else pass_cnt++;
            end
        end
        chk_cnt++; if (wr_count !== 5'd16) $display("FAIL stall_wr_count: got %0d expected 16", wr_count); else pass_cnt++;
        chk_cnt++; if (checksum !== 8'h78) $display("FAIL stall_checksum: got %h expected 78", checksum); else pass_cnt++;
        chk_cnt++; if (done !== 1'b1) $display("FAIL stall_done: got %b expected 1", done); else pass_cnt++;
        for (int a = 0; a <= 16; a++) begin
            if (a > 0) begin
                exp_v = exp_q.pop_front();
                chk_cnt++; if (data_out !== exp_v) $display("FAIL stall_read[%0d]: got %h expected %h", a - 1, data_out, exp_v); else pass_cnt++;
            end
            if (a < 16) begin
                addr_rd = 4'(a);
                exp_q.push_back(8'(a));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'hA0 + 8'(i));
        step(0, 1, 1, 8'hFF);   // abort with a word offered in the same cycle
        chk_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else pass_cnt++;
        chk_cnt++; if (done !== 1'b0) $display("FAIL abort_done: got %b expected 0", done); else pass_cnt++;
        chk_cnt++; if (wr_count !== 5'd5) $display("FAIL abort_wr_count: got %0d expected 5", wr_count); else pass_cnt++;
        // A0+A1+A2+A3+A4 = 0x32A, modulo 256 = 0x2A
        chk_cnt++; if (checksum !== 8'h2A) $display("FAIL abort_checksum: got %h expected 2a", checksum); else pass_cnt++;
        chk_cnt++; if (state_dbg !== 2'd0) $display("FAIL abort_state: got %0d expected 0", state_dbg); else pass_cnt++;
        step(0, 1, 1, 8'hFF);   // abort in IDLE does nothing
        chk_cnt++; if (wr_count !== 5'd5) $display("FAIL abort_idle_count: got %0d expected 5", wr_count); else pass_cnt++;
        // addresses 0..4 hold the new words, address 5 keeps 0x05
        for (int a = 0; a <= 6; a++) begin
            if (a > 0) begin
                exp_v = exp_q.pop_front();
                chk_cnt++; if (data_out !== exp_v) $display("FAIL abort_read[%0d]: got %h expected %h", a - 1, data_out, exp_v); else pass_cnt++;
            end
            if (a < 6) begin
                addr_rd = 4'(a);
                exp_q.push_back(m_mem[a]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_checksum_wrap();
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 8'hFF);
        chk_cnt++; if (checksum !== 8'hF0) $display("FAIL wrap_checksum: got %h expected f0", checksum); else pass_cnt++;
        chk_cnt++; if (done !== 1'b1) $display("FAIL wrap_done: got %b expected 1", done); else pass_cnt++;
        chk_cnt++; if (wr_count !== 5'd16) $display("FAIL wrap_wr_count: got %0d expected 16", wr_count); else pass_cnt++;
    endtask

    task automatic test_reload_collision();
        step(1, 1, 0, 8'h00);   // abort ignored in DONE, start honoured
        chk_cnt++; if (done !== 1'b0) $display("FAIL reload_done: got %b expected 0", done); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL reload_busy: got %b expected 1", busy); else pass_cnt++;
        // first transfer writes addr 0 while addr 0 is being read
        addr_rd = 4'd0;
        exp_q.push_back(m_mem[0]);   // old word
        step(0, 0, 1, 8'h5A);
        exp_v = exp_q.pop_front();
        chk_cnt++; if (data_out !== exp_v) $display("FAIL collide_old: got %h expected %h", data_out, exp_v); else pass_cnt++;
        exp_q.push_back(8'h5A);
        step(0, 0, 0, 8'h00);
        exp_v = exp_q.pop_front();
        chk_cnt++; if (data_out !== exp_v) $display("FAIL collide_new: got %h expected %h", data_out, exp_v); else pass_cnt++;
        step(1, 0, 0, 8'h00);   // start ignored in LOAD
        chk_cnt++; if (wr_count !== 5'd1) $display("FAIL reload_start_ignored: got %0d expected 1", wr_count); else pass_cnt++;
        step(0, 1, 0, 8'h00);
    endtask

    task automatic test_reset_mid_load();
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 8'h30 + 8'(i));
        addr_rd = 4'd3;
        reset_cycle(1, 8'hEE);
        chk_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else pass_cnt++;
        chk_cnt++; if (wr_count !== 5'd0) $display("FAIL midrst_wr_count: got %0d expected 0", wr_count); else pass_cnt++;
        chk_cnt++; if (checksum !== 8'h00) $display("FAIL midrst_checksum: got %h expected 00", checksum); else pass_cnt++;
        chk_cnt++; if (data_out !== 8'h00) $display("FAIL midrst_data_out: got %h expected 00", data_out); else pass_cnt++;
        // words from before the reset survive; the offered 0xEE is not written
        for (int a = 0; a <= 2; a++) begin
            if (a > 0) begin
                exp_v = exp_q.pop_front();
                chk_cnt++; if (data_out !== exp_v) $display("FAIL midrst_read[%0d]: got %h expected %h", a, data_out, exp_v); else pass_cnt++;
            end
            if (a < 2) begin
                addr_rd = (a == 0) ? 4'd3 : 4'd7;
                exp_q.push_back((a == 0) ? 8'h33 : m_mem[7]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 0;
        start = 0;
        abort = 0;
        sif.in_valid = 0;
        sif.in_data = 8'h00;
        addr_rd = 4'd0;
        m_state = 0;
        m_ptr = 0;
        m_count = 0;
        m_csum = 0;
        m_done = 0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_full_load();
        test_stall();
        test_abort();
        test_checksum_wrap();
        test_reload_collision();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
